// File: rtl/store_pkg.sv
// -----------------------------------------------------------------------------
// store_pkg
// Shared definitions for the store-path narrowing unit: RISC-V store funct3
// encodings, completion error codes and the store FSM state type.
// -----------------------------------------------------------------------------
package store_pkg;

  // Store width encodings (instruction funct3 field)
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  // Completion status reported alongside done
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic {
    IDLE,
    WAIT_ACK
  } state_t;

endpackage

// File: rtl/store_lane_formatter.sv
// -----------------------------------------------------------------------------
// store_lane_formatter
// Purely combinational: places the store operand onto the byte lanes of a
// 32-bit data-memory word and produces matching byte strobes. Flags accesses
// that are misaligned for their width and funct3 values that are not stores.
//
// Ports
//   addr       in  2   low byte-address bits
//   data       in  32  rs2 value
//   funct3     in  3   store width encoding
//   wdata      out 32  lane-replicated write data
//   wstrb      out 4   byte write enables
//   misaligned out 1   address not naturally aligned for the width
//   illegal    out 1   funct3 is not SB/SH/SW
// -----------------------------------------------------------------------------
module store_lane_formatter
  import store_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [31:0] data,
  input  logic [2:0]  funct3,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        misaligned,
  output logic        illegal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    wdata      = '0;
    wstrb      = '0;
    misaligned = 1'b0;
    illegal    = 1'b0;

    case (funct3)
      F3_SB: begin
        // Replicating the byte lets memory pick whichever lane the strobe enables.
        wdata = {4{data[7:0]}};
        wstrb = 4'b0001 << addr;
      end
      F3_SH: begin
        wdata      = {2{data[15:0]}};
        wstrb      = addr[1] ? 4'b1100 : 4'b0011;
        misaligned = addr[0];
      end
      F3_SW: begin
        wdata      = data;
        wstrb      = 4'b1111;
        misaligned = |addr;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_narrow_unit.sv
// -----------------------------------------------------------------------------
// store_narrow_unit
// Store path between the execute stage and the data-memory port. Accepts one
// store at a time, narrows it to byte lanes, rejects misaligned or illegal
// requests without touching memory, and holds a single write until it is
// acknowledged or the acknowledge timeout expires.
//
// Parameters
//   TIMEOUT_CYCLES  cycles to wait for mem_ack before aborting (1..255)
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   req_valid/ready request handshake (ready only while idle)
//   req_addr        byte address
//   req_data        rs2 value
//   req_funct3      store width (SB/SH/SW)
//   mem_we          write request, held until ack or timeout
//   mem_addr        word-aligned address
//   mem_wdata       lane-replicated data
//   mem_wstrb       byte enables
//   mem_ack         memory accepted the write
//   done            one-cycle completion pulse
//   err, err_code   completion status, valid with done
// -----------------------------------------------------------------------------
module store_narrow_unit
  import store_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [2:0]  req_funct3,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  // The counter holds the number of ack-less WAIT_ACK cycles already seen, so
  // the cycle that would make it reach TIMEOUT_CYCLES is the one where it
  // equals TIMEOUT_CYCLES-1.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [7:0]  wait_cnt;

  logic [31:0] fmt_wdata;
  logic [3:0]  fmt_wstrb;
  logic        fmt_misaligned;
  logic        fmt_illegal;

  store_lane_formatter u_fmt (
    .addr       (req_addr[1:0]),
    .data       (req_data),
    .funct3     (req_funct3),
    .wdata      (fmt_wdata),
    .wstrb      (fmt_wstrb),
    .misaligned (fmt_misaligned),
    .illegal    (fmt_illegal)
  );

  assign req_ready = (state == IDLE);

  // NOTE: state and outputs use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the write datapath registers are reset too, since they are
      // visible on the memory port and must read zero after reset.
      state     <= IDLE;
      wait_cnt  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      // Completion outputs are pulses; they only stay high when re-asserted.
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;

      case (state)
        IDLE: begin
          if (req_valid) begin
            if (fmt_illegal) begin
              done     <= 1'b1;
              err      <= 1'b1;
              err_code <= ERR_ILLEGAL;
            end else if (fmt_misaligned) begin
              done     <= 1'b1;
              err      <= 1'b1;
              err_code <= ERR_MISALIGN;
            end else begin
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wdata <= fmt_wdata;
              mem_wstrb <= fmt_wstrb;
              mem_we    <= 1'b1;
              wait_cnt  <= '0;
              state     <= WAIT_ACK;
            end
          end
        end

        WAIT_ACK: begin
          // Ack is tested first so it wins over a timeout in the same cycle.
          if (mem_ack) begin
            mem_we <= 1'b0;
            done   <= 1'b1;
            state  <= IDLE;
          end else if (wait_cnt == LAST_WAIT) begin
            mem_we   <= 1'b0;
            done     <= 1'b1;
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_narrow_unit.sv
// -----------------------------------------------------------------------------
// tb_store_narrow_unit
// Scoreboard bench: each request pushes its expected memory write and
// completion status; a negedge monitor pops and compares them as the DUT
// presents them. Latency, reset and timeout behaviour are checked inline.
// A second instance with TIMEOUT_CYCLES = 4 covers the timeout boundary.
// -----------------------------------------------------------------------------
module tb_store_narrow_unit;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } wr_t;

  typedef struct packed {
    logic       err;
    logic [1:0] code;
  } rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;

  // Main instance (default timeout)
  logic        req_valid, req_ready;
  logic [31:0] req_addr, req_data;
  logic [2:0]  req_funct3;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic        done, err;
  logic [1:0]  err_code;

  // Short-timeout instance
  logic        t4_req_valid, t4_req_ready;
  logic [31:0] t4_req_addr, t4_req_data;
  logic [2:0]  t4_req_funct3;
  logic        t4_mem_we;
  logic [31:0] t4_mem_addr, t4_mem_wdata;
  logic [3:0]  t4_mem_wstrb;
  logic        t4_mem_ack;
  logic        t4_done, t4_err;
  logic [1:0]  t4_err_code;

  store_narrow_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_funct3 (req_funct3),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ack    (mem_ack),
    .done       (done),
    .err        (err),
    .err_code   (err_code)
  );

  store_narrow_unit #(.TIMEOUT_CYCLES(4)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (t4_req_valid),
    .req_ready  (t4_req_ready),
    .req_addr   (t4_req_addr),
    .req_data   (t4_req_data),
    .req_funct3 (t4_req_funct3),
    .mem_we     (t4_mem_we),
    .mem_addr   (t4_mem_addr),
    .mem_wdata  (t4_mem_wdata),
    .mem_wstrb  (t4_mem_wstrb),
    .mem_ack    (t4_mem_ack),
    .done       (t4_done),
    .err        (t4_err),
    .err_code   (t4_err_code)
  );

  int n_checks = 0;
  int n_fail   = 0;

  wr_t  wr_q[$];
  rsp_t rsp_q[$];
  wr_t  cur_wr;
  rsp_t cur_rsp;
  logic we_prev = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference narrowing: byte lanes built up one at a time.
  function automatic void model(input logic [31:0] a, input logic [31:0] d,
                                input logic [2:0] f, output wr_t w, output rsp_t r);
    logic [1:0] off;
    off     = a[1:0];
    w.addr  = a & 32'hFFFF_FFFC;
    w.wdata = '0;
    w.wstrb = '0;
    r.err   = 1'b0;
    r.code  = 2'b00;
    case (f)
      3'b000: begin
        for (int i = 0; i < 4; i++) w.wdata[8*i +: 8] = d[7:0];
        w.wstrb[off] = 1'b1;
      end
      3'b001: begin
        for (int i = 0; i < 2; i++) w.wdata[16*i +: 16] = d[15:0];
        w.wstrb = (off >= 2'd2) ? 4'b1100 : 4'b0011;
        if (off == 2'd1 || off == 2'd3) begin r.err = 1'b1; r.code = 2'b01; end
      end
      3'b010: begin
        w.wdata = d;
        w.wstrb = 4'b1111;
        if (off != 2'd0) begin r.err = 1'b1; r.code = 2'b01; end
      end
      default: begin r.err = 1'b1; r.code = 2'b10; end
    endcase
  endfunction

  // Scoreboard monitor on the main instance.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (!we_prev) begin
        check("wr_expected", wr_q.size() != 0, 1);
        if (wr_q.size() != 0) cur_wr = wr_q.pop_front();
      end
      check("wr_addr",  mem_addr,  cur_wr.addr);
      check("wr_wdata", mem_wdata, cur_wr.wdata);
      check("wr_wstrb", mem_wstrb, cur_wr.wstrb);
    end
    if (done === 1'b1) begin
      check("rsp_expected", rsp_q.size() != 0, 1);
      if (rsp_q.size() != 0) begin
        cur_rsp = rsp_q.pop_front();
        check("rsp_err",  err,      cur_rsp.err);
        check("rsp_code", err_code, cur_rsp.code);
      end
    end
    we_prev = (mem_we === 1'b1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ack_delay >= 0: ack after that many ack-less WAIT_ACK cycles.
  // ack_delay == -2: abandon the write with a reset instead.
  task automatic issue(input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f, input int ack_delay);
    wr_t  w;
    rsp_t r;
    model(a, d, f, w, r);
    if (!r.err) wr_q.push_back(w);
    if (ack_delay != -2) rsp_q.push_back(r);
    check("ready_idle", req_ready, 1);
    req_addr   = a;
    req_data   = d;
    req_funct3 = f;
    req_valid  = 1'b1;
    step();
    req_valid  = 1'b0;
    if (r.err) begin
      check("err_done_latency", done, 1);
      check("err_no_we", mem_we, 0);
    end else if (ack_delay == -2) begin
      check("abort_we_up", mem_we, 1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("abort_we", mem_we, 0);
      check("abort_ready", req_ready, 1);
      check("abort_no_done", done, 0);
      check("abort_addr", mem_addr, 0);
      step();
      check("abort_still_no_done", done, 0);
    end else begin
      check("we_after_accept", mem_we, 1);
      check("busy_not_ready", req_ready, 0);
      for (int i = 0; i < ack_delay; i++) begin
        check("wait_no_done", done, 0);
        check("wait_we_held", mem_we, 1);
        step();
      end
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      check("ack_done", done, 1);
      check("ack_we_drop", mem_we, 0);
      check("ack_ready", req_ready, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] b2b_addr [4];
  logic [31:0] b2b_data [4];

  initial begin
    wr_t  w;
    rsp_t r;

    rst_n = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_data = '0; req_funct3 = '0; mem_ack = 1'b0;
    t4_req_valid = 1'b0; t4_req_addr = '0; t4_req_data = '0; t4_req_funct3 = '0;
    t4_mem_ack = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // Reset state
    check("rst_ready", req_ready, 1);
    check("rst_we", mem_we, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_code", err_code, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_wstrb", mem_wstrb, 0);
    check("rst_t4_ready", t4_req_ready, 1);

    // Ack while idle must do nothing
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("idle_ack_no_done", done, 0);
    check("idle_ack_no_we", mem_we, 0);

    // Directed cases
    issue(32'h0000_1003, 32'hAABB_CCDD, 3'b000, 0);  // SB top lane
    issue(32'h0000_2002, 32'h1234_5678, 3'b001, 0);  // SH upper half
    issue(32'h0000_2001, 32'h1234_5678, 3'b001, 0);  // SH misaligned
    issue(32'h0000_3000, 32'hCAFE_F00D, 3'b010, 5);  // SW, late ack
    issue(32'h0000_3000, 32'h0000_0000, 3'b011, 0);  // illegal funct3
    issue(32'h0000_3002, 32'h0BAD_0BAD, 3'b010, 0);  // SW misaligned
    issue(32'h0000_3001, 32'h0BAD_0BAD, 3'b111, 0);  // illegal beats misaligned
    issue(32'h0000_3003, 32'h0BAD_0BAD, 3'b001, 0);  // SH misaligned, odd top
    for (int k = 0; k < 3; k++)
      issue(32'h0000_0040 + k, 32'h0000_0011 * (k + 1), 3'b000, k);
    issue(32'h0000_0040, 32'h8765_4321, 3'b001, 1);  // SH lower half

    // Reset while waiting for ack, then a normal store
    issue(32'h0000_4000, 32'h1111_2222, 3'b010, -2);
    issue(32'h0000_5000, 32'h600D_F00D, 3'b010, 0);

    // Back-to-back SW with req_valid held high and immediate acks
    for (int k = 0; k < 4; k++) begin
      b2b_addr[k] = 32'h0000_6000 + 32'(4 * k);
      b2b_data[k] = $urandom();
    end
    req_funct3 = 3'b010;
    req_addr   = b2b_addr[0];
    req_data   = b2b_data[0];
    req_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      model(b2b_addr[k], b2b_data[k], 3'b010, w, r);
      wr_q.push_back(w);
      rsp_q.push_back(r);
      step();
      check("b2b_we", mem_we, 1);
      check("b2b_no_done", done, 0);
      if (k < 3) begin
        req_addr = b2b_addr[k + 1];
        req_data = b2b_data[k + 1];
      end else begin
        req_valid = 1'b0;
      end
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      check("b2b_done", done, 1);
      check("b2b_ready", req_ready, 1);
    end

    // Timeout with TIMEOUT_CYCLES = 4: done five cycles after acceptance
    t4_req_addr = 32'h0000_7000; t4_req_data = 32'hDEAD_BEEF; t4_req_funct3 = 3'b010;
    t4_req_valid = 1'b1;
    step();
    t4_req_valid = 1'b0;
    check("t4_addr", t4_mem_addr, 32'h0000_7000);
    check("t4_wdata", t4_mem_wdata, 32'hDEAD_BEEF);
    check("t4_wstrb", t4_mem_wstrb, 4'b1111);
    for (int i = 0; i < 4; i++) begin
      check("t4_we_held", t4_mem_we, 1);
      check("t4_no_early_done", t4_done, 0);
      step();
    end
    check("t4_timeout_done", t4_done, 1);
    check("t4_timeout_err", t4_err, 1);
    check("t4_timeout_code", t4_err_code, 2'b11);
    check("t4_timeout_we", t4_mem_we, 0);
    check("t4_timeout_ready", t4_req_ready, 1);
    step();
    check("t4_done_single", t4_done, 0);

    // Ack on the limit cycle wins over timeout
    t4_req_addr = 32'h0000_7004; t4_req_data = 32'h0000_00AB; t4_req_funct3 = 3'b000;
    t4_req_valid = 1'b1;
    step();
    t4_req_valid = 1'b0;
    check("t4_sb_wstrb", t4_mem_wstrb, 4'b0001);
    check("t4_sb_wdata", t4_mem_wdata, 32'hABAB_ABAB);
    for (int i = 0; i < 3; i++) begin
      check("t4_lim_no_done", t4_done, 0);
      step();
    end
    t4_mem_ack = 1'b1;
    step();
    t4_mem_ack = 1'b0;
    check("t4_lim_done", t4_done, 1);
    check("t4_lim_err", t4_err, 0);
    check("t4_lim_code", t4_err_code, 2'b00);

    // Everything expected must have been seen
    step();
    step();
    check("wr_q_drained", wr_q.size(), 0);
    check("rsp_q_drained", rsp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
